// File: rtl/regfile_sb.sv
// Multi-write-port register file with a per-register busy scoreboard and a registered debug read port.
// Optional write-through forwarding on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;
  logic [DATA_W-1:0] r_dbg_data;

  logic              w_we0_ok;
  logic              w_we1_ok;
  logic              w_issue_ok;
  logic [NREG-1:0]   w_busy_nxt;
  logic [DATA_W-1:0] w_rdata_a;
  logic [DATA_W-1:0] w_rdata_b;
  logic              w_busy_a;
  logic              w_busy_b;

  // Register 0 is hard-wired when ZERO_REG is set: its writes and issues are filtered here.
  assign w_we0_ok   = we0      && !((ZERO_REG != 0) && (waddr0 == '0));
  assign w_we1_ok   = we1      && !((ZERO_REG != 0) && (waddr1 == '0));
  assign w_issue_ok = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));

  // Retiring writes clear their busy bit; a same-cycle issue to that register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_we0_ok)   w_busy_nxt[waddr0]     = 1'b0;
    if (w_we1_ok)   w_busy_nxt[waddr1]     = 1'b0;
    if (w_issue_ok) w_busy_nxt[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_busy     <= '0;
      r_dbg_data <= '0;
    end else begin
      if (w_we0_ok) r_regs[waddr0] <= wdata0;
      // Port 1 is assigned last so it wins a same-address collision.
      if (w_we1_ok) r_regs[waddr1] <= wdata1;
      r_busy     <= w_busy_nxt;
      r_dbg_data <= r_regs[dbg_addr];
    end
  end

  always_comb begin
    w_rdata_a = r_regs[raddr_a];
    w_busy_a  = r_busy[raddr_a];
    if ((ZERO_REG != 0) && (raddr_a == '0)) begin
      w_rdata_a = '0;
      w_busy_a  = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    if (w_we1_ok && (waddr1 == raddr_a)) begin
      w_rdata_a = wdata1;
      w_busy_a  = w_issue_ok && (issue_addr == raddr_a);
    end else if (w_we0_ok && (waddr0 == raddr_a)) begin
      w_rdata_a = wdata0;
      w_busy_a  = w_issue_ok && (issue_addr == raddr_a);
    end
`endif
  end

  always_comb begin
    w_rdata_b = r_regs[raddr_b];
    w_busy_b  = r_busy[raddr_b];
    if ((ZERO_REG != 0) && (raddr_b == '0)) begin
      w_rdata_b = '0;
      w_busy_b  = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    if (w_we1_ok && (waddr1 == raddr_b)) begin
      w_rdata_b = wdata1;
      w_busy_b  = w_issue_ok && (issue_addr == raddr_b);
    end else if (w_we0_ok && (waddr0 == raddr_b)) begin
      w_rdata_b = wdata0;
      w_busy_b  = w_issue_ok && (issue_addr == raddr_b);
    end
`endif
  end

  assign rdata_a  = w_rdata_a;
  assign rdata_b  = w_rdata_b;
  assign busy_a   = w_busy_a;
  assign busy_b   = w_busy_b;
  assign dbg_data = r_dbg_data;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters); expectations follow REGFILE_BYPASS_EN.
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              we0;
  logic [ADDR_W-1:0] waddr0;
  logic [DATA_W-1:0] wdata0;
  logic              we1;
  logic [ADDR_W-1:0] waddr1;
  logic [DATA_W-1:0] wdata1;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              busy_a;
  logic              busy_b;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_v;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Clock / reset defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past one rising edge; inputs set afterwards apply at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rst = 1'b0; we0 = 1'b0; we1 = 1'b0; issue_en = 1'b0;
    waddr0 = '0; wdata0 = '0; waddr1 = '0; wdata1 = '0;
    issue_addr = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    raddr_a = 5'd5; raddr_b = 5'd31; dbg_addr = 5'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (rdata_a !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_a: got %h expected %h", rdata_a, 32'h0); end
    n_checks++; if (rdata_b !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_b: got %h expected %h", rdata_b, 32'h0); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %b expected 0", busy_b); end
    n_checks++; if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL reset_dbg: got %h expected %h", dbg_data, 32'h0); end
  endtask

  task automatic test_write_read();
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEADBEEF;
    tick();
    we0 = 1'b0; raddr_a = 5'd3;
    #1;
    n_checks++; if (rdata_a !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_read_r3: got %h expected %h", rdata_a, 32'hDEADBEEF); end
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h1234; raddr_b = 5'd0;
    tick();
    we0 = 1'b0;
    #1;
    n_checks++; if (rdata_b !== 32'h0) begin n_fail++; $display("FAIL write_r0_ignored: got %h expected %h", rdata_b, 32'h0); end
    // Debug port returns the stored value one cycle after the address is applied.
    dbg_addr = 5'd3; exp_q.push_back(32'hDEADBEEF);
    tick();
    exp_v = exp_q.pop_front();
    n_checks++; if (dbg_data !== exp_v) begin n_fail++; $display("FAIL dbg_r3: got %h expected %h", dbg_data, exp_v); end
    dbg_addr = 5'd0; exp_q.push_back(32'h0);
    tick();
    exp_v = exp_q.pop_front();
    n_checks++; if (dbg_data !== exp_v) begin n_fail++; $display("FAIL dbg_r0: got %h expected %h", dbg_data, exp_v); end
  endtask

  task automatic test_dual_write();
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    tick();
    we0 = 1'b0; we1 = 1'b0; raddr_a = 5'd7;
    #1;
    n_checks++; if (rdata_a !== 32'h22) begin n_fail++; $display("FAIL collision_r7: got %h expected %h", rdata_a, 32'h22); end
    we0 = 1'b1; waddr0 = 5'd8; wdata0 = 32'hA8;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'hB9;
    tick();
    we0 = 1'b0; we1 = 1'b0; raddr_a = 5'd8; raddr_b = 5'd9;
    #1;
    n_checks++; if (rdata_a !== 32'hA8) begin n_fail++; $display("FAIL dual_r8: got %h expected %h", rdata_a, 32'hA8); end
    n_checks++; if (rdata_b !== 32'hB9) begin n_fail++; $display("FAIL dual_r9: got %h expected %h", rdata_b, 32'hB9); end
  endtask

  task automatic test_scoreboard();
    raddr_a = 5'd4; raddr_b = 5'd5;
    issue_en = 1'b1; issue_addr = 5'd4;
    #1;
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL busy_before_edge: got %b expected 0", busy_a); end
    tick();
    issue_en = 1'b0;
    #1;
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL busy_after_issue: got %b expected 1", busy_a); end
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL busy_other_reg: got %b expected 0", busy_b); end
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h44;
    tick();
    we0 = 1'b0;
    #1;
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL busy_cleared: got %b expected 0", busy_a); end
    n_checks++; if (rdata_a !== 32'h44) begin n_fail++; $display("FAIL retire_data_r4: got %h expected %h", rdata_a, 32'h44); end
    issue_en = 1'b1; issue_addr = 5'd4;
    we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h45;
    tick();
    issue_en = 1'b0; we1 = 1'b0;
    #1;
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear: got %b expected 1", busy_a); end
    n_checks++; if (rdata_a !== 32'h45) begin n_fail++; $display("FAIL set_clear_data: got %h expected %h", rdata_a, 32'h45); end
    // Writing a non-busy register leaves its busy bit at 0.
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h55;
    tick();
    we0 = 1'b0;
    #1;
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL write_nonbusy: got %b expected 0", busy_b); end
    issue_en = 1'b1; issue_addr = 5'd0; raddr_b = 5'd0;
    tick();
    issue_en = 1'b0;
    #1;
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL issue_r0: got %b expected 0", busy_b); end
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL busy_r4_held: got %b expected 1", busy_a); end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] exp_same_a;
    logic [DATA_W-1:0] exp_same_b;
    logic              exp_busy_same;
    we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h1111;
    issue_en = 1'b1; issue_addr = 5'd6;
    tick();
    we0 = 1'b0; issue_en = 1'b0;
`ifdef REGFILE_BYPASS_EN
    exp_same_a = 32'hCAFE; exp_same_b = 32'hBBBB; exp_busy_same = 1'b0;
`else
    exp_same_a = 32'h1111; exp_same_b = 32'hCAFE; exp_busy_same = 1'b1;
`endif
    we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'hCAFE; raddr_a = 5'd6;
    #1;
    n_checks++; if (rdata_a !== exp_same_a) begin n_fail++; $display("FAIL bypass_same_cycle: got %h expected %h", rdata_a, exp_same_a); end
    n_checks++; if (busy_a !== exp_busy_same) begin n_fail++; $display("FAIL bypass_busy: got %b expected %b", busy_a, exp_busy_same); end
    tick();
    we1 = 1'b0;
    #1;
    n_checks++; if (rdata_a !== 32'hCAFE) begin n_fail++; $display("FAIL bypass_next_cycle: got %h expected %h", rdata_a, 32'hCAFE); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL bypass_busy_next: got %b expected 0", busy_a); end
    we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'hAAAA;
    we1 = 1'b1; waddr1 = 5'd6; wdata1 = 32'hBBBB; raddr_b = 5'd6;
    #1;
    n_checks++; if (rdata_b !== exp_same_b) begin n_fail++; $display("FAIL bypass_priority: got %h expected %h", rdata_b, exp_same_b); end
    tick();
    we0 = 1'b0; we1 = 1'b0;
    #1;
    n_checks++; if (rdata_b !== 32'hBBBB) begin n_fail++; $display("FAIL priority_stored: got %h expected %h", rdata_b, 32'hBBBB); end
  endtask

  task automatic test_reset_mid();
    we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'h55;
    issue_en = 1'b1; issue_addr = 5'd2;
    tick();
    we0 = 1'b0; issue_en = 1'b0; raddr_a = 5'd2; raddr_b = 5'd3;
    #1;
    n_checks++; if (rdata_a !== 32'h55) begin n_fail++; $display("FAIL pre_reset_r2: got %h expected %h", rdata_a, 32'h55); end
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy2: got %b expected 1", busy_a); end
    rst = 1'b1; we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'h99; dbg_addr = 5'd2;
    tick();
    rst = 1'b0; we0 = 1'b0;
    #1;
    n_checks++; if (rdata_a !== 32'h0) begin n_fail++; $display("FAIL reset_mid_r2: got %h expected %h", rdata_a, 32'h0); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy2: got %b expected 0", busy_a); end
    n_checks++; if (rdata_b !== 32'h0) begin n_fail++; $display("FAIL reset_mid_r3: got %h expected %h", rdata_b, 32'h0); end
    n_checks++; if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL reset_mid_dbg: got %h expected %h", dbg_data, 32'h0); end
    tick();
    n_checks++; if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL dbg_after_reset: got %h expected %h", dbg_data, 32'h0); end
  endtask

  initial begin
    drive_idle();
    raddr_a = '0; raddr_b = '0; dbg_addr = '0;
    test_reset();
    test_write_read();
    test_dual_write();
    test_scoreboard();
    test_bypass();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
